// File: rtl/flexcount_ff_if.sv
// Control/status bundle for flexcount_ff: count controls in, state and terminal count out.
interface flexcount_ff_if #(
   parameter int WIDTH = 5
);
   logic             enable;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] q;
   logic             tc;

   modport master (output enable, up_dn, load, load_value, input q, tc);
   modport slave  (input enable, up_dn, load, load_value, output q, tc);
endinterface

// File: rtl/flexcount_ff.sv
// Parametrised counter: one next-state function (binary/gray/johnson) feeding an array of
// D, T, JK or RS flip-flop primitives; every realization yields the same q sequence.

module flexcount_dff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   logic q_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else         q_q <= d_i;
   end
   assign q_o = q_q;
endmodule

module flexcount_tff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic t_i,
   output logic q_o
);
   logic q_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else         q_q <= q_q ^ t_i;
   end
   assign q_o = q_q;
endmodule

module flexcount_jkff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic j_i,
   input  logic k_i,
   output logic q_o
);
   logic q_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else begin
         case ({j_i, k_i})
            2'b10:   q_q <= 1'b1;
            2'b01:   q_q <= 1'b0;
            2'b11:   q_q <= ~q_q;
            default: q_q <= q_q;
         endcase
      end
   end
   assign q_o = q_q;
endmodule

module flexcount_rsff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic s_i,
   input  logic r_i,
   output logic q_o
);
   logic q_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else begin
         case ({s_i, r_i})
            2'b10:   q_q <= 1'b1;
            2'b01:   q_q <= 1'b0;
            default: q_q <= q_q;
         endcase
      end
   end
   assign q_o = q_q;

   // Excitation is derived from q and nxt, so set and reset are mutually exclusive.
   a_no_sr: assert property (@(posedge clk_i) disable iff (!rst_ni) !(s_i && r_i));
endmodule

module flexcount_ff #(
   parameter int    WIDTH       = 5,
   parameter string REALIZATION = "d-type",
   parameter string MODE        = "binary",
   parameter int    MODULUS     = 2**WIDTH
) (
   input  logic          clock,
   input  logic          reset_n,
   flexcount_ff_if.slave bus
);
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] term_up;

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("flexcount_ff: WIDTH must be in 2..16");
   end

   // ---------------- count code ----------------
   if (MODE == "binary") begin : g_bin
      if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_mod
         $error("flexcount_ff: MODULUS out of range");
      end
      localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
      localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
      logic oor;

      // Loaded values beyond the modulus re-enter the legal range at the wrap point.
      assign oor     = {1'b0, q_q} >= MOD_X;
      assign term_up = LAST;
      always_comb begin
         if (bus.up_dn) cnt_nxt = (oor || q_q == LAST) ? '0 : q_q + 1'b1;
         else           cnt_nxt = (oor || q_q == '0)  ? LAST : q_q - 1'b1;
      end
   end else if (MODE == "gray") begin : g_gray
      logic [WIDTH-1:0] idx;
      logic [WIDTH-1:0] idx_n;

      assign term_up = {1'b1, {(WIDTH-1){1'b0}}};
      always_comb begin
         idx[WIDTH-1] = q_q[WIDTH-1];
         for (int i = WIDTH-2; i >= 0; i--) idx[i] = idx[i+1] ^ q_q[i];
         idx_n   = bus.up_dn ? idx + 1'b1 : idx - 1'b1;
         cnt_nxt = idx_n ^ (idx_n >> 1);
      end
   end else if (MODE == "johnson") begin : g_john
      logic [WIDTH-2:0] edges;
      logic             valid;

      // A legal Johnson word has at most one boundary between a run of 1s and a run of 0s.
      assign edges   = q_q[WIDTH-1:1] ^ q_q[WIDTH-2:0];
      assign valid   = (edges & (edges - 1'b1)) == '0;
      assign term_up = {1'b1, {(WIDTH-1){1'b0}}};
      always_comb begin
         if (!valid)         cnt_nxt = '0;
         else if (bus.up_dn) cnt_nxt = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
         else                cnt_nxt = {~q_q[0], q_q[WIDTH-1:1]};
      end
   end else begin : g_bad_mode
      $error("flexcount_ff: unknown MODE");
      assign cnt_nxt = q_q;
      assign term_up = '0;
   end

   // ---------------- target vector: load > enable > hold ----------------
   always_comb begin
      nxt = q_q;
      if (bus.load)        nxt = bus.load_value;
      else if (bus.enable) nxt = cnt_nxt;
   end

   // ---------------- flip-flop realization ----------------
   if (REALIZATION == "d-type") begin : g_d
      flexcount_dff u_ff [WIDTH-1:0] (
         .clk_i (clock), .rst_ni(reset_n), .d_i(nxt), .q_o(q_q));
   end else if (REALIZATION == "t-type") begin : g_t
      logic [WIDTH-1:0] t_exc;
      assign t_exc = q_q ^ nxt;
      flexcount_tff u_ff [WIDTH-1:0] (
         .clk_i (clock), .rst_ni(reset_n), .t_i(t_exc), .q_o(q_q));
   end else if (REALIZATION == "jk-type") begin : g_jk
      logic [WIDTH-1:0] j_exc;
      logic [WIDTH-1:0] k_exc;
      assign j_exc = nxt & ~q_q;
      assign k_exc = ~nxt & q_q;
      flexcount_jkff u_ff [WIDTH-1:0] (
         .clk_i (clock), .rst_ni(reset_n), .j_i(j_exc), .k_i(k_exc), .q_o(q_q));
   end else if (REALIZATION == "rs-type") begin : g_rs
      logic [WIDTH-1:0] s_exc;
      logic [WIDTH-1:0] r_exc;
      assign s_exc = nxt & ~q_q;
      assign r_exc = ~nxt & q_q;
      flexcount_rsff u_ff [WIDTH-1:0] (
         .clk_i (clock), .rst_ni(reset_n), .s_i(s_exc), .r_i(r_exc), .q_o(q_q));
   end else begin : g_bad_real
      $error("flexcount_ff: unknown REALIZATION");
      assign q_q = '0;
   end

   assign bus.q  = q_q;
   assign bus.tc = bus.enable & ~bus.load & (bus.up_dn ? (q_q == term_up) : (q_q == '0));
endmodule
